host_dma_scheduler: RTL and testbench
=====================================

Name: host_dma_scheduler

Overview:
Command-level sequencer in front of host_dma_engineer. Accepts one inference job from the host: weights address, source/destination addresses and image count. Optionally issues a weight load, then splits the images into batches of at most MAX_BATCH and issues one model_start per batch with per-batch addresses. It tracks write-back completion by counting AXI write responses, and reports done, error and progress to host control registers.

Parameters:
ADDR_WIDTH, 32, AXI address width
BEAT_BYTES, 64, bytes per AXI beat (512-bit bus)
IN_BEATS_PER_IMAGE, 128, input beats read per image
OUT_BEATS_PER_IMAGE, 1, write-back beats produced per image
MAX_BATCH, 16, maximum images per model_start
TIMEOUT_CYCLES, 16777216, watchdog limit per wait state (0 disables the watchdog)

Ports:
clk  in  1  sole clock
m_axi_aresetn  in  1  reset; asynchronous assert, active-low
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_reload_weights  in  1  force weight load even if weights_loaded
cmd_image_num  in  32  images in job
cmd_weights_addr  in  ADDR_WIDTH  host weight buffer
cmd_src_addr  in  ADDR_WIDTH  host input base
cmd_dst_addr  in  ADDR_WIDTH  host output base
load_weights  out  1  one-cycle pulse to engine
model_start  out  1  one-cycle pulse to engine
image_num  out  32  batch image count, stable from pulse until batch end
host_weights_addr  out  ADDR_WIDTH  stable copy of job weights address
host_src_addr  out  ADDR_WIDTH  batch source address
host_dst_addr  out  ADDR_WIDTH  batch destination address
ddr_load_done  in  1  pulse from DDR writer: weight image committed
wr_resp_valid  in  1  monitored m_axi_bvalid (engine bready is always 1)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on job completion
error  out  1  sticky watchdog flag; cleared by next accepted command
weights_loaded  out  1  sticky; cleared only by reset or at the LOAD_W entry
batches_done  out  32  completed batches in current job

Behaviour:
- Reset values: every output and register is 0; state IDLE.
- Reset mid-job drops the job immediately; no further pulses are issued.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch all cmd_* fields, clear error and batches_done.
  - Next state: LOAD_W if cmd_reload_weights or !weights_loaded; otherwise START_B if cmd_image_num != 0; otherwise DONE.
- LOAD_W: clear weights_loaded; drive load_weights=1 for exactly one cycle; go to WAIT_W.
- WAIT_W: on ddr_load_done, set weights_loaded and go to START_B, or DONE if image_num is 0.
- START_B:
  - Compute batch = min(remaining, MAX_BATCH).
  - Register image_num, host_src_addr and host_dst_addr one cycle before the pulse.
  - Then pulse model_start for one cycle.
  - Clear resp_cnt; expected = batch*OUT_BEATS_PER_IMAGE.
  - Go to RUN_B.
- RUN_B:
  - resp_cnt increments on each wr_resp_valid.
  - When resp_cnt == expected: batches_done++, remaining -= batch.
  - src += batch*IN_BEATS_PER_IMAGE*BEAT_BYTES; dst += batch*OUT_BEATS_PER_IMAGE*BEAT_BYTES.
  - Next state: START_B if remaining != 0, else DONE.
- DONE: done=1 for one cycle, then IDLE.
- Pulse spacing: load_weights/model_start pulses are at least 2 cycles apart and never coincide, because the engine detects pulses by rising edge.
- Address arithmetic: modulo 2^ADDR_WIDTH (wraps silently). Products are computed at 64-bit width, then truncated.
- wr_resp_valid in any state other than RUN_B is ignored.
- A response arriving in the same cycle resp_cnt reaches expected counts normally.
- Watchdog:
  - Counter resets on entry to WAIT_W or RUN_B and on each ddr_load_done/wr_resp_valid.
  - On reaching TIMEOUT_CYCLES: set error, go to DONE (done still pulses); weights_loaded is left 0 if the timeout was in WAIT_W.
- cmd_valid while busy is ignored; the command is not queued.

Decomposition:
- Package host_dma_pkg: state enum (IDLE, LOAD_W, WAIT_W, START_B, RUN_B, DONE) and the default beat constants (128, 64, 16). host_dma_engineer switches to the same constants.
- One sub-module, dma_watchdog: load/clear/expire counter with a TIMEOUT_CYCLES parameter.
- FSM and address datapath stay in host_dma_scheduler.

Test Plan:
- Cold job, image_num=5, reload=0 → one load_weights pulse; after ddr_load_done, one model_start with image_num=5, src=cmd_src, dst=cmd_dst; 5 responses → done pulse, batches_done=1, weights_loaded=1.
- Warm job, image_num=40, MAX_BATCH=16, src=0x1000_0000, dst=0x2000_0000 → no load_weights; three model_start pulses with image_num 16/16/8; src 0x1000_0000/0x1002_0000/0x1004_0000; dst 0x2000_0000/0x2000_0400/0x2000_0800; batches_done=3.
- image_num=0 with reload=1 → weight load only, then done; no model_start.
- TIMEOUT_CYCLES=100, withhold responses after 3 of 5 → error=1 at cycle 100 after last response, done pulses, busy falls; next command clears error.
- Address wrap: src=0xFFFF_F000, image_num=32 → second batch src=0x0001_F000.
- Reset asserted during RUN_B → all outputs 0 asynchronously; later cmd_valid accepted normally with weights_loaded=0, forcing a reload.

Source files
------------

// File: rtl/host_dma_pkg.sv
// Shared types and default geometry for the host DMA scheduler and engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package host_dma_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        WAIT_W  = 3'd2,
        START_B = 3'd3,
        RUN_B   = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Default beat geometry; host_dma_engineer uses the same values.
    localparam int unsigned DEF_IN_BEATS_PER_IMAGE = 128;
    localparam int unsigned DEF_BEAT_BYTES         = 64;
    localparam int unsigned DEF_MAX_BATCH          = 16;

    // Size of a run of images in bytes (or beats when bytes_per_beat is 1).
    // Computed at 64 bits so callers can truncate to their address width.
    function automatic logic [63:0] span_bytes(input logic [31:0] count,
                                               input int unsigned beats,
                                               input int unsigned bytes_per_beat);
        return 64'(count) * 64'(beats) * 64'(bytes_per_beat);
    endfunction

endpackage

// File: rtl/dma_watchdog.sv
// Idle-cycle watchdog: counts cycles spent waiting with no progress event.
// Latency: expired_o is combinational on the cycle the count reaches the limit.
// Backpressure: none; run_i low or clear_i high holds the counter at zero.
module dma_watchdog
    import host_dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned     CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit              ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]   LIMIT  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: zero whenever not waiting or progress was seen, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!ENABLE || !run_i || clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = ENABLE && run_i && !clear_i && (cnt_q == LIMIT);

endmodule

// File: rtl/host_dma_scheduler.sv
// Job sequencer in front of host_dma_engineer: optional weight load, then batched model_start pulses.
// Latency: batch image_num/addresses are registered one cycle before each model_start; done pulses in DONE.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped, not queued.
module host_dma_scheduler
    import host_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH          = 32,
    parameter int unsigned BEAT_BYTES          = DEF_BEAT_BYTES,
    parameter int unsigned IN_BEATS_PER_IMAGE  = DEF_IN_BEATS_PER_IMAGE,
    parameter int unsigned OUT_BEATS_PER_IMAGE = 1,
    parameter int unsigned MAX_BATCH           = DEF_MAX_BATCH,
    parameter int unsigned TIMEOUT_CYCLES      = 16777216
) (
    input  logic                  clk,
    input  logic                  m_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_reload_weights,
    input  logic [31:0]           cmd_image_num,
    input  logic [ADDR_WIDTH-1:0] cmd_weights_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
    output logic                  load_weights,
    output logic                  model_start,
    output logic [31:0]           image_num,
    output logic [ADDR_WIDTH-1:0] host_weights_addr,
    output logic [ADDR_WIDTH-1:0] host_src_addr,
    output logic [ADDR_WIDTH-1:0] host_dst_addr,
    input  logic                  ddr_load_done,
    input  logic                  wr_resp_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  weights_loaded,
    output logic [31:0]           batches_done
);

    state_t                state_q;
    logic                  arm_q;            // START_B second cycle: outputs already set up
    logic [ADDR_WIDTH-1:0] src_q;            // source base of the next batch
    logic [ADDR_WIDTH-1:0] dst_q;            // destination base of the next batch
    logic [31:0]           remaining_q;      // images not yet completed
    logic [31:0]           resp_cnt_q;
    logic [31:0]           expected_q;
    logic [31:0]           image_num_q;
    logic [ADDR_WIDTH-1:0] weights_addr_q;
    logic [ADDR_WIDTH-1:0] host_src_q;
    logic [ADDR_WIDTH-1:0] host_dst_q;
    logic                  load_weights_q;
    logic                  model_start_q;
    logic                  done_q;
    logic                  error_q;
    logic                  weights_loaded_q;
    logic [31:0]           batches_done_q;

    logic [31:0]           batch_d;
    logic [31:0]           expected_d;
    logic [31:0]           resp_cnt_d;
    logic [ADDR_WIDTH-1:0] src_step_d;
    logic [ADDR_WIDTH-1:0] dst_step_d;
    logic                  batch_hit;
    logic                  last_batch;
    logic                  wd_run;
    logic                  wd_expired;

    // Batch sizing and per-batch address strides. image_num_q holds the
    // size of the batch in flight while in RUN_B.
    assign batch_d    = (remaining_q > 32'(MAX_BATCH)) ? 32'(MAX_BATCH) : remaining_q;
    assign expected_d = 32'(span_bytes(batch_d, OUT_BEATS_PER_IMAGE, 1));
    assign src_step_d = ADDR_WIDTH'(span_bytes(image_num_q, IN_BEATS_PER_IMAGE, BEAT_BYTES));
    assign dst_step_d = ADDR_WIDTH'(span_bytes(image_num_q, OUT_BEATS_PER_IMAGE, BEAT_BYTES));

    // A response landing on the cycle the count reaches expected still counts.
    assign resp_cnt_d = resp_cnt_q + {31'd0, wr_resp_valid};
    assign batch_hit  = (resp_cnt_d == expected_q);
    assign last_batch = (remaining_q == image_num_q);

    // The watchdog only runs in the two wait states and restarts on any progress.
    assign wd_run = (state_q == WAIT_W) || (state_q == RUN_B);

    dma_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (m_axi_aresetn),
        .run_i     (wd_run),
        .clear_i   (ddr_load_done | wr_resp_valid),
        .expired_o (wd_expired)
    );

    // Job FSM with registered pulses, addresses and status.
    always_ff @(posedge clk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q          <= IDLE;
            arm_q            <= 1'b0;
            src_q            <= '0;
            dst_q            <= '0;
            remaining_q      <= '0;
            resp_cnt_q       <= '0;
            expected_q       <= '0;
            image_num_q      <= '0;
            weights_addr_q   <= '0;
            host_src_q       <= '0;
            host_dst_q       <= '0;
            load_weights_q   <= 1'b0;
            model_start_q    <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            weights_loaded_q <= 1'b0;
            batches_done_q   <= '0;
        end else begin
            load_weights_q <= 1'b0;
            model_start_q  <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        weights_addr_q <= cmd_weights_addr;
                        src_q          <= cmd_src_addr;
                        dst_q          <= cmd_dst_addr;
                        remaining_q    <= cmd_image_num;
                        error_q        <= 1'b0;
                        batches_done_q <= '0;
                        if (cmd_reload_weights || !weights_loaded_q) begin
                            state_q <= LOAD_W;
                        end else if (cmd_image_num != 32'd0) begin
                            state_q <= START_B;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    weights_loaded_q <= 1'b0;
                    load_weights_q   <= 1'b1;
                    state_q          <= WAIT_W;
                end
                WAIT_W: begin
                    if (ddr_load_done) begin
                        weights_loaded_q <= 1'b1;
                        if (remaining_q != 32'd0) begin
                            state_q <= START_B;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        error_q <= 1'b1;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                START_B: begin
                    if (!arm_q) begin
                        // Present the batch to the engine a cycle ahead of the pulse.
                        image_num_q <= batch_d;
                        host_src_q  <= src_q;
                        host_dst_q  <= dst_q;
                        expected_q  <= expected_d;
                        arm_q       <= 1'b1;
                    end else begin
                        arm_q         <= 1'b0;
                        model_start_q <= 1'b1;
                        resp_cnt_q    <= '0;
                        state_q       <= RUN_B;
                    end
                end
                RUN_B: begin
                    resp_cnt_q <= resp_cnt_d;
                    if (batch_hit) begin
                        batches_done_q <= batches_done_q + 32'd1;
                        remaining_q    <= remaining_q - image_num_q;
                        src_q          <= src_q + src_step_d;
                        dst_q          <= dst_q + dst_step_d;
                        if (last_batch) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= START_B;
                        end
                    end else if (wd_expired) begin
                        error_q <= 1'b1;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // cmd_ready is gated by reset so every output reads 0 while reset is held.
    assign cmd_ready         = m_axi_aresetn && (state_q == IDLE);
    assign busy              = (state_q != IDLE);
    assign load_weights      = load_weights_q;
    assign model_start       = model_start_q;
    assign image_num         = image_num_q;
    assign host_weights_addr = weights_addr_q;
    assign host_src_addr     = host_src_q;
    assign host_dst_addr     = host_dst_q;
    assign done              = done_q;
    assign error             = error_q;
    assign weights_loaded    = weights_loaded_q;
    assign batches_done      = batches_done_q;

endmodule

// File: tb/tb_host_dma_scheduler.sv
// Scoreboard bench for host_dma_scheduler: reference job model pushes expected events,
// a monitor pops them on load_weights/model_start/done, a responder plays DDR writer and AXI B channel.
`timescale 1ns/1ps
module tb_host_dma_scheduler;

    localparam int TO    = 100;
    localparam int IN_B  = 128;
    localparam int BB    = 64;
    localparam int OUT_B = 1;
    localparam int MB    = 16;

    localparam int K_LOAD  = 0;
    localparam int K_START = 1;
    localparam int K_DONE  = 2;

    logic        clk;
    logic        m_axi_aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_reload_weights;
    logic [31:0] cmd_image_num;
    logic [31:0] cmd_weights_addr;
    logic [31:0] cmd_src_addr;
    logic [31:0] cmd_dst_addr;
    logic        load_weights;
    logic        model_start;
    logic [31:0] image_num;
    logic [31:0] host_weights_addr;
    logic [31:0] host_src_addr;
    logic [31:0] host_dst_addr;
    logic        ddr_load_done;
    logic        wr_resp_valid;
    logic        busy;
    logic        done;
    logic        error;
    logic        weights_loaded;
    logic [31:0] batches_done;

    host_dma_scheduler #(
        .ADDR_WIDTH          (32),
        .BEAT_BYTES          (BB),
        .IN_BEATS_PER_IMAGE  (IN_B),
        .OUT_BEATS_PER_IMAGE (OUT_B),
        .MAX_BATCH           (MB),
        .TIMEOUT_CYCLES      (TO)
    ) dut (
        .clk                (clk),
        .m_axi_aresetn      (m_axi_aresetn),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_reload_weights (cmd_reload_weights),
        .cmd_image_num      (cmd_image_num),
        .cmd_weights_addr   (cmd_weights_addr),
        .cmd_src_addr       (cmd_src_addr),
        .cmd_dst_addr       (cmd_dst_addr),
        .load_weights       (load_weights),
        .model_start        (model_start),
        .image_num          (image_num),
        .host_weights_addr  (host_weights_addr),
        .host_src_addr      (host_src_addr),
        .host_dst_addr      (host_dst_addr),
        .ddr_load_done      (ddr_load_done),
        .wr_resp_valid      (wr_resp_valid),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .weights_loaded     (weights_loaded),
        .batches_done       (batches_done)
    );

    typedef struct {
        int          kind;
        logic [31:0] num;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] waddr;
        logic [31:0] bd;
        logic [31:0] err;
        logic [31:0] wl;
    } ev_t;

    ev_t sbq[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  resp_limit = 1000;
    int  last_resp_cyc = 0;
    bit  m_wl = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: derive the whole event sequence of a job from its fields.
    function automatic void push_job(input bit reload, input logic [31:0] n, input logic [31:0] wa,
                                     input logic [31:0] s_in, input logic [31:0] d_in, input int limit);
        ev_t         e;
        logic [31:0] rem;
        logic [31:0] s;
        logic [31:0] d;
        int          b;
        int          bd;
        bit          err;
        rem = n; s = s_in; d = d_in; bd = 0; err = 0;
        e = '{default: '0};
        if (reload || !m_wl) begin
            e.kind = K_LOAD; e.waddr = wa;
            sbq.push_back(e);
            m_wl = 1;
        end
        while (rem != 0 && !err) begin
            b = (rem > MB) ? MB : int'(rem);
            e = '{default: '0};
            e.kind = K_START; e.num = b; e.src = s; e.dst = d;
            sbq.push_back(e);
            if (limit < b * OUT_B) begin
                err = 1;
            end else begin
                bd++;
                rem = rem - b;
                s = s + 32'(b * IN_B * BB);
                d = d + 32'(b * OUT_B * BB);
            end
        end
        e = '{default: '0};
        e.kind = K_DONE; e.bd = bd; e.err = {31'd0, err}; e.wl = {31'd0, m_wl};
        sbq.push_back(e);
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every pulse or done must match the head of the scoreboard.
    initial begin
        ev_t e;
        int  last_pulse;
        last_pulse = -100;
        forever begin
            @(negedge clk);
            if (m_axi_aresetn && (load_weights || model_start || done)) begin
                if (load_weights || model_start) begin
                    chk("pulse_gap_ok", {31'd0, (cyc - last_pulse) >= 2}, 32'd1);
                    last_pulse = cyc;
                end
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_event: lw=%0b ms=%0b done=%0b with empty scoreboard (cycle %0d)",
                             load_weights, model_start, done, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (load_weights) begin
                        chk("pulse_coincide", {31'd0, model_start}, 32'd0);
                        chk("lw_kind", e.kind, K_LOAD);
                        chk("lw_weights_addr", host_weights_addr, e.waddr);
                    end else if (model_start) begin
                        chk("ms_kind", e.kind, K_START);
                        chk("ms_image_num", image_num, e.num);
                        chk("ms_src", host_src_addr, e.src);
                        chk("ms_dst", host_dst_addr, e.dst);
                    end else begin
                        chk("done_kind", e.kind, K_DONE);
                        chk("done_batches", batches_done, e.bd);
                        chk("done_error", {31'd0, error}, e.err);
                        chk("done_wl", {31'd0, weights_loaded}, e.wl);
                    end
                end
            end
        end
    end

    // Responder: DDR writer completion and AXI write responses with random gaps,
    // plus stray responses while idle or loading weights that must be ignored.
    initial begin
        int pend_resp;
        int gap;
        bit pend_load;
        bit drove;
        pend_resp = 0; gap = 0; pend_load = 0;
        wr_resp_valid = 0; ddr_load_done = 0;
        forever begin
            @(negedge clk);
            wr_resp_valid = 0; ddr_load_done = 0; drove = 0;
            if (!m_axi_aresetn) begin
                pend_resp = 0; pend_load = 0; gap = 0;
            end else begin
                if (load_weights) begin
                    pend_load = 1;
                    gap = $urandom_range(0, 4);
                end
                if (model_start) begin
                    pend_resp = ((int'(image_num) * OUT_B) < resp_limit) ? int'(image_num) * OUT_B : resp_limit;
                    gap = $urandom_range(0, 3);
                end
                if (gap > 0) begin
                    gap--;
                end else if (pend_load) begin
                    ddr_load_done = 1; pend_load = 0; drove = 1;
                end else if (pend_resp > 0) begin
                    wr_resp_valid = 1; pend_resp--; drove = 1;
                    last_resp_cyc = cyc;
                    gap = $urandom_range(0, 3);
                end
                if (!drove && (!busy || pend_load) && $urandom_range(0, 3) == 0) wr_resp_valid = 1;
            end
        end
    end

    task automatic send_cmd(input bit reload, input logic [31:0] n, input logic [31:0] wa,
                            input logic [31:0] s, input logic [31:0] d);
        int i;
        i = 0;
        @(negedge clk);
        while (!cmd_ready && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL cmd_ready_wait: cmd_ready stayed 0 for %0d cycles", i);
        end
        cmd_reload_weights = reload; cmd_image_num = n;
        cmd_weights_addr = wa; cmd_src_addr = s; cmd_dst_addr = d;
        push_job(reload, n, wa, s, d, resp_limit);
        cmd_valid = 1;
        @(negedge clk);
        // A second command while busy must be dropped.
        cmd_reload_weights = 1; cmd_image_num = $urandom_range(1, 60);
        cmd_weights_addr = $urandom; cmd_src_addr = $urandom; cmd_dst_addr = $urandom;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles", i);
        end
    endtask

    task automatic run_job(input bit reload, input logic [31:0] n, input logic [31:0] wa,
                           input logic [31:0] s, input logic [31:0] d);
        send_cmd(reload, n, wa, s, d);
        wait_idle();
        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 32'd0);
    endtask

    initial begin
        int i;
        int delta;
        cmd_valid = 0; cmd_reload_weights = 0; cmd_image_num = 0;
        cmd_weights_addr = 0; cmd_src_addr = 0; cmd_dst_addr = 0;
        m_axi_aresetn = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_wl", {31'd0, weights_loaded}, 32'd0);
        chk("rst_batches", batches_done, 32'd0);
        chk("rst_image_num", image_num, 32'd0);
        chk("rst_pulses", {30'd0, load_weights, model_start}, 32'd0);
        m_axi_aresetn = 1;
        @(negedge clk);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Cold job: weight load forced by empty weights.
        run_job(0, 5, 32'hAAAA_0000, 32'h3000_0000, 32'h4000_0000);
        chk("cold_wl", {31'd0, weights_loaded}, 32'd1);
        chk("cold_batches", batches_done, 32'd1);

        // Warm job split into 16/16/8.
        run_job(0, 40, 32'hAAAA_0000, 32'h1000_0000, 32'h2000_0000);
        chk("warm_batches", batches_done, 32'd3);

        // Weight load only, then warm empty job.
        run_job(1, 0, 32'hBBBB_0000, 32'h0, 32'h0);
        run_job(0, 0, 32'hBBBB_0000, 32'h0, 32'h0);

        // Source address wraps past 2^32 on the second batch.
        run_job(0, 32, 32'hCCCC_0000, 32'hFFFF_F000, 32'h7000_0000);

        // Watchdog: only 3 of 5 responses.
        resp_limit = 3;
        send_cmd(0, 5, 32'hCCCC_0000, 32'h0100_0000, 32'h0200_0000);
        i = 0;
        while (!error && i < 1000) begin
            @(negedge clk);
            i++;
        end
        delta = cyc - last_resp_cyc;
        chk("timeout_error_set", {31'd0, error}, 32'd1);
        chk("timeout_delay_ok", {31'd0, (delta >= TO) && (delta <= TO + 2)}, 32'd1);
        wait_idle();
        resp_limit = 1000;
        @(negedge clk);
        chk("timeout_busy_low", {31'd0, busy}, 32'd0);
        chk("error_sticky", {31'd0, error}, 32'd1);
        chk("timeout_sb_drained", sbq.size(), 32'd0);

        // Next accepted command clears the error.
        send_cmd(0, 3, 32'hCCCC_0000, 32'h0300_0000, 32'h0400_0000);
        chk("error_cleared", {31'd0, error}, 32'd0);
        wait_idle();
        @(negedge clk);
        chk("clear_sb_drained", sbq.size(), 32'd0);

        // Reset during RUN_B drops the job and the loaded weights.
        send_cmd(0, 40, 32'hDDDD_0000, 32'h5000_0000, 32'h6000_0000);
        i = 0;
        while (!model_start && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("midrun_started", {31'd0, model_start}, 32'd1);
        repeat (3) @(negedge clk);
        #2 m_axi_aresetn = 0;
        sbq.delete();
        m_wl = 0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("midrst_wl", {31'd0, weights_loaded}, 32'd0);
        chk("midrst_src", host_src_addr, 32'd0);
        chk("midrst_dst", host_dst_addr, 32'd0);
        chk("midrst_waddr", host_weights_addr, 32'd0);
        chk("midrst_image_num", image_num, 32'd0);
        chk("midrst_pulses", {29'd0, load_weights, model_start, done}, 32'd0);
        repeat (2) @(negedge clk);
        #2 m_axi_aresetn = 1;
        repeat (5) @(negedge clk);
        chk("postrst_quiet", {30'd0, load_weights, model_start}, 32'd0);
        run_job(0, 7, 32'hEEEE_0000, 32'h0800_0000, 32'h0900_0000);
        chk("postrst_wl", {31'd0, weights_loaded}, 32'd1);

        // Random jobs.
        for (int k = 0; k < 10; k++) begin
            run_job($urandom_range(0, 3) == 0, $urandom_range(0, 50), $urandom, $urandom, $urandom);
        end

        chk("final_sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "global timeout");
    end

endmodule
